// File: rtl/sccb_master_fsm.sv
// sccb_master_fsm: write-only SCCB master, start + 27 bit-slots + stop per request
module sccb_master_fsm #(
  parameter bit DC_BIT_DRIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] req_dev_id_i,
  input  logic [7:0] req_sub_addr_i,
  input  logic [7:0] req_data_i,
  output logic       cntr_en_o,
  input  logic       tick_en_i,
  input  logic       sio_c_tgl_en_i,
  output logic       sio_c_o,
  output logic       sio_d_o,
  output logic       sio_d_oe_o,
  output logic       busy_o,
  output logic       done_o
);
  typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;
  state_t      state;
  logic [1:0]  phase_cnt;
  logic [3:0]  bit_cnt;
  logic        half;
  logic [23:0] shreg;
  assign req_ready_o = state == IDLE;
  assign busy_o      = ~req_ready_o;
  assign cntr_en_o   = state != IDLE;
  // sequencer: SIO_D moves on tick_en, SIO_C toggles on sio_c_tgl_en; shreg MSB is the next bit
  always_ff @(posedge clk) begin
    done_o <= 1'b0;
    if (!rst_n) begin
      state      <= IDLE;
      phase_cnt  <= 2'd0;
      bit_cnt    <= 4'd0;
      half       <= 1'b0;
      shreg      <= 24'd0;
      sio_c_o    <= 1'b1;
      sio_d_o    <= 1'b1;
      sio_d_oe_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sio_c_o    <= 1'b1;
          sio_d_o    <= 1'b1;
          sio_d_oe_o <= 1'b1;
          if (req_valid_i) begin
            shreg     <= {req_dev_id_i, 1'b0, req_sub_addr_i, req_data_i};
            phase_cnt <= 2'd0;
            bit_cnt   <= 4'd0;
            half      <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick_en_i) sio_d_o <= 1'b0;
          else if (sio_c_tgl_en_i) begin
            sio_c_o <= 1'b0;
            half    <= 1'b0;
            state   <= BIT;
          end
        end
        BIT: begin
          if (tick_en_i && !half) begin
            sio_d_oe_o <= bit_cnt == 4'd8 ? DC_BIT_DRIVE : 1'b1;
            sio_d_o    <= bit_cnt == 4'd8 ? ~DC_BIT_DRIVE : shreg[23];
          end else if (sio_c_tgl_en_i) begin
            sio_c_o <= ~half;
            half    <= ~half;
            if (half) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt   <= 4'd0;
                phase_cnt <= phase_cnt == 2'd2 ? 2'd0 : phase_cnt + 2'd1;
                if (phase_cnt == 2'd2) state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {shreg[22:0], 1'b0};
              end
            end
          end
        end
        STOP: begin
          if (tick_en_i) begin
            sio_d_oe_o <= 1'b1;
            sio_d_o    <= half;
          end else if (sio_c_tgl_en_i) begin
            if (half) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end else begin
              sio_c_o <= 1'b1;
              half    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_master_fsm.sv
// tb_sccb_master_fsm: scoreboard bench for both DC_BIT_DRIVE settings with a modeled N=8 timing generator
module tb_sccb_master_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_id = 7'd0;
  logic [7:0] req_sub = 8'd0;
  logic [7:0] req_data = 8'd0;
  logic       ftick = 1'b0;
  logic       ftgl = 1'b0;
  logic [2:0] gcnt = 3'd0;
  logic       tick, tgl;
  logic       rdy0, en0, c0, d0, oe0, busy0, done0;
  logic       rdy1, en1, c1, d1, oe1, busy1, done1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] bq[$];
  int         dq[$];
  int         acc = 0;
  bit         acc_v = 1'b0;
  bit         armed = 1'b0;
  logic       rst_q = 1'b1;
  logic       pc = 1'b1, pd = 1'b1;
  int         starts = 0, stops = 0, nrise = 0;
  logic       en_exp, done_exp;
  logic [23:0] bytes_l;
  logic [3:0]  got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // timing generator model, half-period 8: tick at count 4, toggle at count 7
  always @(posedge clk) gcnt <= en0 ? gcnt + 3'd1 : 3'd0;
  assign tick = (en0 && gcnt == 3'd4) | ftick;
  assign tgl  = (en0 && gcnt == 3'd7) | ftgl;

  sccb_master_fsm #(.DC_BIT_DRIVE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy0),
    .req_dev_id_i(req_id), .req_sub_addr_i(req_sub), .req_data_i(req_data),
    .cntr_en_o(en0), .tick_en_i(tick), .sio_c_tgl_en_i(tgl),
    .sio_c_o(c0), .sio_d_o(d0), .sio_d_oe_o(oe0), .busy_o(busy0), .done_o(done0)
  );
  sccb_master_fsm #(.DC_BIT_DRIVE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1),
    .req_dev_id_i(req_id), .req_sub_addr_i(req_sub), .req_data_i(req_data),
    .cntr_en_o(en1), .tick_en_i(tick), .sio_c_tgl_en_i(tgl),
    .sio_c_o(c1), .sio_d_o(d1), .sio_d_oe_o(oe1), .busy_o(busy1), .done_o(done1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", tag, act, exp, cyc);
    end
  endtask

  // monitor: per-cycle control checks, slot sampling on SIO_C rise, accept -> scoreboard push
  always @(negedge clk) begin
    if (!rst_q) begin
      bq.delete();
      dq.delete();
      acc_v = 1'b0;
      starts = 0;
      stops = 0;
      nrise = 0;
      armed = 1'b1;
      chk("rst_out0", {c0, d0, oe0, en0, rdy0, busy0, done0}, 7'b1110100);
      chk("rst_out1", {c1, d1, oe1, en1, rdy1, busy1, done1}, 7'b1110100);
    end else if (armed) begin
      en_exp   = acc_v && cyc > acc && cyc <= acc + 456;
      done_exp = dq.size() > 0 && dq[0] == cyc;
      chk("cntr_en", en0, en_exp);
      chk("ready_busy", {rdy0, busy0}, {~en_exp, en_exp});
      chk("done", done0, done_exp);
      chk("dut1_ctl", {c1, en1, rdy1, busy1, done1}, {c0, en_exp, ~en_exp, en_exp, done_exp});
      if (!en_exp) begin
        chk("idle_bus0", {c0, d0, oe0}, 3'b111);
        chk("idle_bus1", {c1, d1, oe1}, 3'b111);
      end
      if (c0 && pc && d0 != pd) begin
        if (!d0) starts++;
        else stops++;
      end
      if (done_exp) begin
        void'(dq.pop_front());
        chk("starts", starts, 1);
        chk("stops", stops, 1);
        chk("slots_left", bq.size(), 0);
        starts = 0;
        stops = 0;
      end
      if (c0 && !pc) begin
        nrise++;
        chk("slot_avail", bq.size() > 0, 1);
        if (bq.size() > 0) begin
          got = {oe0, d0, oe1, d1};
          chk($sformatf("slot%0d", nrise), got, bq.pop_front());
        end
      end
      if (req_valid && rdy0) begin
        acc = cyc;
        acc_v = 1'b1;
        nrise = 0;
        dq.push_back(cyc + 457);
        bytes_l = {req_id, 1'b0, req_sub, req_data};
        for (int p = 0; p < 3; p++) begin
          for (int i = 0; i < 8; i++)
            bq.push_back({1'b1, bytes_l[23-p*8-i], 1'b1, bytes_l[23-p*8-i]});
          bq.push_back(4'b0110);
        end
        bq.push_back(4'b1010);
      end
    end
    pc = c0;
    pd = d0;
    rst_q = rst_n;
  end

  task automatic send(input logic [6:0] id, input logic [7:0] s, input logic [7:0] d, output int a);
    req_valid = 1'b1;
    req_id = id;
    req_sub = s;
    req_data = d;
    a = -1;
    for (int k = 0; k < 2000 && a < 0; k++) begin
      @(negedge clk);
      if (rdy0) a = cyc;
    end
    chk("accept", a >= 0, 1);
    @(posedge clk) #1;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 1000 && !done0; k++) @(negedge clk);
    chk("done_seen", done0, 1);
    @(posedge clk) #1;
  endtask

  initial begin
    int a1, a2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk) #1;
      req_valid = 1'($urandom);
      req_id = 7'($urandom);
      req_sub = 8'($urandom);
      req_data = 8'($urandom);
      ftick = 1'($urandom);
      ftgl = 1'($urandom);
    end
    @(posedge clk) #1;
    rst_n = 1'b1;
    req_valid = 1'b0;
    ftick = 1'b0;
    ftgl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(7'h21, 8'h12, 8'h80, a1);
    req_valid = 1'b0;
    wait_done();
    for (int k = 0; k < 12; k++) begin
      @(posedge clk) #1;
      ftick = k[0];
      ftgl = ~k[0];
      req_id = 7'($urandom);
    end
    @(posedge clk) #1;
    ftick = 1'b0;
    ftgl = 1'b0;
    send(7'h21, 8'h00, 8'hFF, a1);
    send(7'h30, 8'hA5, 8'h5A, a2);
    req_valid = 1'b0;
    chk("b2b_accept", a2, a1 + 457);
    wait_done();
    send(7'h55, 8'h3C, 8'hC3, a1);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk) #1;
      req_valid = 1'($urandom);
      req_id = 7'($urandom);
      req_sub = 8'($urandom);
      req_data = 8'($urandom);
    end
    req_valid = 1'b0;
    wait_done();
    send(7'h7F, 8'hFE, 8'h01, a1);
    req_valid = 1'b0;
    for (int k = 0; k < 1000 && nrise < 10; k++) @(posedge clk);
    chk("rise10", nrise, 10);
    #1 rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(7'h0A, 8'h5C, 8'h3E, a1);
    req_valid = 1'b0;
    wait_done();
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sccb_master_fsm.md
# sccb_master_fsm

Write-only SCCB master sequencer that owns the SIO_C/SIO_D pins and runs the SCCB timing generator. It accepts one 3-phase write request (7-bit device ID + W bit, sub-address, data) over a valid/ready handshake, then enables the timing generator and advances the bus one bit-slot at a time on its strobes. It emits start, 27 bit-slots and stop, then pulses done. It sits between the register-configuration logic (camera init sequencer) and the SCCB pad drivers.

## Interface
- DC_BIT_DRIVE, 0, 9th (don't-care) bit of each phase: 0 = release SIO_D (oe low), 1 = drive SIO_D low.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  write request valid.
- req_ready_o  out  1  high only in IDLE; request accepted on a cycle with valid & ready.
- req_dev_id_i  in  7  slave ID; transmitted as {id, 1'b0}.
- req_sub_addr_i  in  8  register sub-address.
- req_data_i  in  8  write data.
- cntr_en_o  out  1  enable to timing generator; high in every non-IDLE state.
- tick_en_i  in  1  mid-half-period strobe from timing generator.
- sio_c_tgl_en_i  in  1  end-of-half-period strobe from timing generator.
- sio_c_o  out  1  SIO_C level.
- sio_d_o  out  1  SIO_D level when driven; 1 when released.
- sio_d_oe_o  out  1  SIO_D output enable.
- busy_o  out  1  equals ~req_ready_o.
- done_o  out  1  one-cycle pulse on transaction completion.

## Operation
- States: IDLE, START, BIT, STOP. Counters: phase_cnt (0..2), bit_cnt (0..8), half flag (0 = SIO_C low half, 1 = high half). Shift data latched as 24-bit {id,0,sub,data} on accept.
- IDLE: sio_c_o=1, sio_d_o=1, sio_d_oe_o=1, cntr_en_o=0, ready=1. On accept: latch request, go START, clear counters.
- START (1 half-period, SIO_C high): tick_en -> sio_d_o=0. sio_c_tgl_en -> sio_c_o=0, go BIT, half=0.
- BIT, half=0: tick_en -> drive current bit (MSB first); for bit_cnt=8 apply DC_BIT_DRIVE (oe=0/sio_d=1, or oe=1/sio_d=0). sio_c_tgl_en -> sio_c_o=1, half=1.
- BIT, half=1: SIO_D held. sio_c_tgl_en -> sio_c_o=0, half=0; bit_cnt+1, wrapping 8->0 with phase_cnt+1; after phase 2 bit 8, go STOP.
- STOP, half=0: tick_en -> sio_d_oe_o=1, sio_d_o=0. sio_c_tgl_en -> sio_c_o=1, half=1.
- STOP, half=1: tick_en -> sio_d_o=1. sio_c_tgl_en -> go IDLE, done_o=1 for next cycle.
- SIO_D changes only at tick_en while SIO_C low, except start (falls while SIO_C high) and stop (rises while SIO_C high).
- Strobes ignored in IDLE. Request inputs ignored while busy; requester holds them until ready.
- Timing generator must be configured for half-period N >= 4 so tick_en and sio_c_tgl_en never coincide.

## Timing
- Reset (rst_n low at a clock edge): next cycle state=IDLE, sio_c_o=1, sio_d_o=1, sio_d_oe_o=1, cntr_en_o=0, req_ready_o=1, busy_o=0, done_o=0, counters 0. Mid-transaction reset abandons the transfer without a stop condition and without a done pulse. Dropping cntr_en_o clears the generator counter.
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- Transaction spans 57 half-periods (1 start + 54 bit + 2 stop). With accept in cycle A, cntr_en_o is high from A+1. done_o is high in cycle A+57N+1, with ready high in the same cycle. For N=625 at 125 MHz: 35,626 cycles.
- Back-to-back: a request held valid is accepted in the done cycle. Minimum SIO_C/SIO_D idle-high between stop and next start is one half-period.

## Test plan
- Reset: hold rst_n low 3 cycles with random inputs -> all outputs at reset values; no done.
- Single write with bench-modeled strobes N=8 (tick at count 4, tgl at count 7): id=7'h21, sub=8'h12, data=8'h80 -> start seen; SIO_D sampled on SIO_C rising edges = 0x42,dc,0x12,dc,0x80,dc; stop seen; done at A+457; cntr_en_o high A+1..A+456.
- DC_BIT_DRIVE=0 vs 1 -> during each 9th slot, oe=0 vs oe=1 with sio_d=0; all other slots oe=1.
- Back-to-back: two requests (0x21/0x00/0xFF, then 0x30/0xA5/0x5A) with valid held -> second accepted in first done cycle; ready low throughout each transfer; both byte streams correct.
- Reset at the 10th SIO_C rise -> next cycle SIO_C=1, SIO_D=1, cntr_en_o=0, ready=1, no done. A new request then completes normally.
- Spurious strobes in IDLE and request changes while busy -> no bus activity; latched bytes unchanged.
